// File: rtl/lsu.sv
// Load/store unit: one memory op at a time, 8-byte-aligned data-memory requests,
// byte-lane store shifting/strobing and load alignment with sign/zero extension.
module lsu #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic              dmem_we_o,
  output logic [STRB_W-1:0] dmem_wstrb_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_rsp_valid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              done_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              misalign_o
);

  // Valid/ready: a transfer happens on a rising edge where both valid and ready
  // are high; while valid is high without ready, every payload signal holds.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [2:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic              misalign_q, misalign_d;

  logic              accept;
  logic              misaligned;
  logic [2:0]        in_off;
  logic [STRB_W-1:0] in_mask;
  logic [XLEN-1:0]   rsp_sh;
  logic [XLEN-1:0]   rsp_ext;

  assign in_off = addr_i[2:0];
  assign accept = (state_q == S_IDLE) && req_valid_i && (load_i || store_i);

  always_comb begin
    misaligned = 1'b0;
    in_mask    = '1;
    case (size_i)
      2'd0: begin
        misaligned = 1'b0;
        in_mask    = STRB_W'(8'h01);
      end
      2'd1: begin
        misaligned = addr_i[0];
        in_mask    = STRB_W'(8'h03);
      end
      2'd2: begin
        misaligned = (addr_i[1:0] != 2'b00);
        in_mask    = STRB_W'(8'h0F);
      end
      default: begin
        misaligned = (addr_i[2:0] != 3'b000);
        in_mask    = '1;
      end
    endcase
  end

  // Response is shifted down by the captured byte offset, then extended by size.
  assign rsp_sh = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    rsp_ext = rsp_sh;
    case (size_q)
      2'd0: rsp_ext = uns_q ? XLEN'(rsp_sh[7:0])  : {{(XLEN-8){rsp_sh[7]}}, rsp_sh[7:0]};
      2'd1: rsp_ext = uns_q ? XLEN'(rsp_sh[15:0]) : {{(XLEN-16){rsp_sh[15]}}, rsp_sh[15:0]};
      2'd2: rsp_ext = uns_q ? XLEN'(rsp_sh[31:0]) : {{(XLEN-32){rsp_sh[31]}}, rsp_sh[31:0]};
      default: rsp_ext = rsp_sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    done_d      = 1'b0;
    load_data_d = load_data_q;
    misalign_d  = misalign_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d = S_REQ;
            addr_d  = {addr_i[XLEN-1:3], 3'b000};
            we_d    = store_i;
            wstrb_d = in_mask << in_off;
            wdata_d = wdata_i << {in_off, 3'b000};
            off_d   = in_off;
            size_d  = size_i;
            uns_d   = unsigned_i;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready_i) begin
          if (we_q) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            misalign_d = 1'b0;
          end else begin
            state_d = S_WAIT_RSP;
          end
        end
      end
      S_WAIT_RSP: begin
        if (dmem_rsp_valid_i) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          misalign_d  = 1'b0;
          load_data_d = rsp_ext;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o      = (state_q == S_IDLE);
    dmem_req_valid_o = (state_q == S_REQ);
    dmem_addr_o      = addr_q;
    dmem_we_o        = we_q;
    dmem_wstrb_o     = wstrb_q;
    dmem_wdata_o     = wdata_q;
    done_o           = done_q;
    load_data_o      = load_data_q;
    misalign_o       = misalign_q;
  end

endmodule
